// File: rtl/axis_combiner_pkg.sv
// Shared types and helpers for the AXI-stream combiner: arbitration modes, sideband widths
// and a width-generic sign extension.
package axis_combiner_pkg;

  typedef enum logic {RR, FIXED} arb_mode_t;

  localparam int DEST_WIDTH = 8;
  localparam int USER_WIDTH = 8;
  localparam int MAX_W      = 128;

  // Sign-extends the low src_w bits of din across the full MAX_W-bit word.
  function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] din, input int src_w);
    logic signed [MAX_W-1:0] v;
    v = din << (MAX_W - src_w);
    return v >>> (MAX_W - src_w);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// One-hot request arbiter, combinational grant, round-robin from an internal pointer or fixed
// lowest-index priority; the pointer moves past the winner only when i_advance marks a transfer.
module axis_rr_arbiter
  import axis_combiner_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_t MODE = RR
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         i_req,
  input  logic                 i_advance,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_grant_vld
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = (MODE == FIXED) ? k : k + int'(r_ptr);
      if (pos >= N) pos = pos - N;
      if (!o_grant_vld && i_req[PW'(pos)]) begin
        o_grant_vld          = 1'b1;
        o_grant_idx          = PW'(pos);
        o_grant[PW'(pos)]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == PW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_combiner_n.sv
// N-input AXI-stream merger into one registered output (1-cycle latency, 1 beat/clk, full valid/ready
// backpressure) with per-channel periodic tlast; AXIS_COMBINER_STALL_CNT_EN adds per-input stall counters.
module axi_stream_combiner_n
  import axis_combiner_pkg::*;
#(
  parameter int    N_STREAMS         = 4,
  parameter int    INPUT_DATA_WIDTH  = 16,
  parameter int    OUTPUT_DATA_WIDTH = 32,
  parameter int    TLAST_PERIOD      = 1024,
  parameter string MSB_DEST_SUPPORT  = "TRUE",
  parameter string ARBITRATION       = "ROUND_ROBIN"
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N_STREAMS*INPUT_DATA_WIDTH-1:0] i_stream_in_data,
  input  logic [N_STREAMS*DEST_WIDTH-1:0]       i_stream_in_dest,
  input  logic [N_STREAMS*USER_WIDTH-1:0]       i_stream_in_user,
  input  logic [N_STREAMS-1:0]                  i_stream_in_valid,
  output logic [N_STREAMS-1:0]                  o_stream_in_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]          o_stream_out_data,
  output logic [DEST_WIDTH-1:0]                 o_stream_out_dest,
  output logic [USER_WIDTH-1:0]                 o_stream_out_user,
  output logic                                  o_stream_out_valid,
  output logic                                  o_stream_out_tlast,
  input  logic                                  i_stream_out_ready
`ifdef AXIS_COMBINER_STALL_CNT_EN
  ,
  output logic [N_STREAMS*16-1:0]               o_stall_count
`endif
);

  localparam int N  = N_STREAMS;
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int BW = OW - DEST_WIDTH;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TLAST_PERIOD) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TLAST_PERIOD - 1);
  localparam arb_mode_t ARB_MODE = (ARBITRATION == "FIXED") ? FIXED : RR;

  logic [N-1:0]          w_grant;
  logic [PW-1:0]         w_sel_idx;
  logic                  w_grant_vld;
  logic                  w_load_en;
  logic                  w_xfer;
  logic                  w_tlast_hit;
  logic [IW-1:0]         w_sel_data;
  logic [DEST_WIDTH-1:0] w_sel_dest;
  logic [USER_WIDTH-1:0] w_sel_user;
  logic [OW-1:0]         w_out_data;

  logic                  r_out_vld;
  logic                  r_out_tlast;
  logic [OW-1:0]         r_out_data;
  logic [DEST_WIDTH-1:0] r_out_dest;
  logic [USER_WIDTH-1:0] r_out_user;
  logic [CW-1:0]         r_cnt [N];

  axis_rr_arbiter #(
    .N    (N),
    .MODE (ARB_MODE)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .i_req       (i_stream_in_valid),
    .i_advance   (w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_sel_idx),
    .o_grant_vld (w_grant_vld)
  );

  // The output register takes a new beat whenever it is empty or being drained this cycle.
  assign w_load_en         = ~r_out_vld | i_stream_out_ready;
  assign o_stream_in_ready = w_grant & {N{w_load_en & reset}};
  assign w_xfer            = w_load_en & w_grant_vld & reset;

  assign w_sel_data  = i_stream_in_data[w_sel_idx*IW +: IW];
  assign w_sel_dest  = i_stream_in_dest[w_sel_idx*DEST_WIDTH +: DEST_WIDTH];
  assign w_sel_user  = i_stream_in_user[w_sel_idx*USER_WIDTH +: USER_WIDTH];
  assign w_tlast_hit = (r_cnt[w_sel_idx] == LAST_CNT);

  generate
    if (MSB_DEST_SUPPORT == "TRUE") begin : g_dest_msb
      logic [BW-1:0] w_ext;
      assign w_ext      = BW'(sign_extend(MAX_W'(w_sel_data), IW));
      assign w_out_data = {w_sel_dest, w_ext};
    end else begin : g_sign_ext
      assign w_out_data = OW'(sign_extend(MAX_W'(w_sel_data), IW));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_out_vld   <= 1'b0;
      r_out_tlast <= 1'b0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
      r_out_user  <= '0;
    end else if (w_load_en) begin
      r_out_vld   <= w_grant_vld;
      r_out_tlast <= w_grant_vld & w_tlast_hit;
      if (w_grant_vld) begin
        r_out_data <= w_out_data;
        r_out_dest <= w_sel_dest;
        r_out_user <= w_sel_user;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else if (w_xfer) begin
      r_cnt[w_sel_idx] <= w_tlast_hit ? '0 : r_cnt[w_sel_idx] + 1'b1;
    end
  end

  assign o_stream_out_valid = r_out_vld;
  assign o_stream_out_tlast = r_out_tlast;
  assign o_stream_out_data  = r_out_data;
  assign o_stream_out_dest  = r_out_dest;
  assign o_stream_out_user  = r_out_user;

`ifdef AXIS_COMBINER_STALL_CNT_EN
  logic [15:0] r_stall [N];

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        r_stall[i] <= '0;
      end else if (i_stream_in_valid[i] && !o_stream_in_ready[i] && r_stall[i] != 16'hFFFF) begin
        r_stall[i] <= r_stall[i] + 16'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stall
      assign o_stall_count[16*gi +: 16] = r_stall[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_axi_stream_combiner_n.sv
// Bench for axi_stream_combiner_n: directed vectors, a transaction-level reference model compared every
// cycle, a beat scoreboard, and a FIXED-priority instance sharing the same inputs.
module tb_axi_stream_combiner_n;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int TP = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    in_vld  = '0;
  logic [N*IW-1:0] in_dat  = '0;
  logic [N*8-1:0]  in_dest = '0;
  logic [N*8-1:0]  in_user = '0;
  logic            out_rdy = 1'b0;
  logic [N-1:0]    in_rdy, fx_rdy;
  logic [OW-1:0]   out_dat, fx_dat;
  logic [7:0]      out_dest, out_user, fx_dest, fx_user;
  logic            out_vld, out_tlast, fx_vld, fx_tlast;
`ifdef AXIS_COMBINER_STALL_CNT_EN
  logic [N*16-1:0] stall, fx_stall;
`endif

  axi_stream_combiner_n #(
    .N_STREAMS(N), .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .TLAST_PERIOD(TP),
    .MSB_DEST_SUPPORT("TRUE"), .ARBITRATION("ROUND_ROBIN")
  ) u_dut (
    .clock(clock), .reset(reset),
    .i_stream_in_data(in_dat), .i_stream_in_dest(in_dest), .i_stream_in_user(in_user),
    .i_stream_in_valid(in_vld), .o_stream_in_ready(in_rdy),
    .o_stream_out_data(out_dat), .o_stream_out_dest(out_dest), .o_stream_out_user(out_user),
    .o_stream_out_valid(out_vld), .o_stream_out_tlast(out_tlast), .i_stream_out_ready(out_rdy)
`ifdef AXIS_COMBINER_STALL_CNT_EN
    , .o_stall_count(stall)
`endif
  );

  axi_stream_combiner_n #(
    .N_STREAMS(N), .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .TLAST_PERIOD(TP),
    .MSB_DEST_SUPPORT("TRUE"), .ARBITRATION("FIXED")
  ) u_fx (
    .clock(clock), .reset(reset),
    .i_stream_in_data(in_dat), .i_stream_in_dest(in_dest), .i_stream_in_user(in_user),
    .i_stream_in_valid(in_vld), .o_stream_in_ready(fx_rdy),
    .o_stream_out_data(fx_dat), .o_stream_out_dest(fx_dest), .o_stream_out_user(fx_user),
    .o_stream_out_valid(fx_vld), .o_stream_out_tlast(fx_tlast), .i_stream_out_ready(out_rdy)
`ifdef AXIS_COMBINER_STALL_CNT_EN
    , .o_stall_count(fx_stall)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  dest;
    logic [7:0]  user;
  } beat_t;

  beat_t       srcq [N][$];
  logic [47:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_in  = 0;
  int          n_out = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [15:0] d, input logic [7:0] dest, input logic [7:0] user);
    beat_t b;
    b.d = d; b.dest = dest; b.user = user;
    return b;
  endfunction

  // Output word: dest in the top byte, the signed sample as a 24-bit two's-complement value below it.
  function automatic logic [31:0] exp_data(input logic [15:0] d, input logic [7:0] dest);
    int s;
    s = $signed(d);
    return {dest, s[23:0]};
  endfunction

  function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  logic        m_vld = 1'b0, m_tlast = 1'b0;
  logic [31:0] m_dat = '0;
  logic [7:0]  m_dest = '0, m_user = '0;
  int          m_ptr = 0;
  int          m_cnt [N];
  int          m_stall [N];

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (reset && (!m_vld || out_rdy)) begin
      w = rr_winner(in_vld, m_ptr);
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clock) begin : model
    logic [N-1:0] r;
    int w, ptr;
    int c [N];
    int st [N];
    logic v, t;
    r = m_ready();
    ptr = m_ptr; v = m_vld; t = m_tlast;
    for (int i = 0; i < N; i++) begin c[i] = m_cnt[i]; st[i] = m_stall[i]; end
    if (!reset) begin
      m_vld <= 1'b0; m_tlast <= 1'b0; m_dat <= '0; m_dest <= '0; m_user <= '0;
      ptr = 0;
      for (int i = 0; i < N; i++) begin c[i] = 0; st[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) if (in_vld[i] && !r[i] && st[i] < 65535) st[i]++;
      if (!m_vld || out_rdy) begin
        w = rr_winner(in_vld, m_ptr);
        if (w < 0) begin
          v = 1'b0; t = 1'b0;
        end else begin
          v = 1'b1;
          c[w]++;
          t = (c[w] == TP);
          if (t) c[w] = 0;
          ptr = (w + 1) % N;
          m_dat  <= exp_data(in_dat[w*IW +: IW], in_dest[w*8 +: 8]);
          m_dest <= in_dest[w*8 +: 8];
          m_user <= in_user[w*8 +: 8];
        end
      end
      m_vld <= v; m_tlast <= t;
    end
    m_ptr <= ptr;
    for (int i = 0; i < N; i++) begin m_cnt[i] <= c[i]; m_stall[i] <= st[i]; end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_in_ready", in_rdy, m_ready());
      check("m_out_valid", out_vld, m_vld);
      check("m_out_tlast", out_tlast, m_tlast);
      if (m_vld) begin
        check("m_out_data", out_dat, m_dat);
        check("m_out_dest", out_dest, m_dest);
        check("m_out_user", out_user, m_user);
      end
`ifdef AXIS_COMBINER_STALL_CNT_EN
      for (int i = 0; i < N; i++) check("m_stall_count", stall[16*i +: 16], 64'(m_stall[i]));
`endif
    end
  end

  // ---------------- driver / scoreboard ----------------
  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        in_vld[i]          = 1'b1;
        in_dat[i*IW +: IW] = srcq[i][0].d;
        in_dest[i*8 +: 8]  = srcq[i][0].dest;
        in_user[i*8 +: 8]  = srcq[i][0].user;
      end else begin
        in_vld[i]          = 1'b0;
        in_dat[i*IW +: IW] = '0;
        in_dest[i*8 +: 8]  = '0;
        in_user[i*8 +: 8]  = '0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] rdy_s;
    logic         acc_o, rst_s;
    logic [47:0]  o_s, e;
    beat_t        b;
    @(negedge clock);
    rdy_s = in_rdy; acc_o = out_vld & out_rdy; rst_s = reset;
    o_s = {out_dat, out_dest, out_user};
    @(posedge clock);
    #1;
    if (!rst_s) begin
      sb.delete();
    end else begin
      if (acc_o) begin
        check("sb_beat_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_out++;
          check("sb_beat", o_s, e);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (in_vld[i] && rdy_s[i]) begin
          b = srcq[i].pop_front();
          sb.push_back({exp_data(b.d, b.dest), b.dest, b.user});
          n_in++;
        end
      end
    end
    apply_inputs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_inputs();
    cycle();
    chk_en = 1'b1;

    // Reset state: a valid input must not see ready while reset is low.
    srcq[2].push_back(mk(16'h1234, 8'd2, 8'd0));
    apply_inputs();
    cycle();
    check("rst_in_ready", in_rdy, 4'b0000);
    check("rst_out_valid", out_vld, 1'b0);
    check("rst_out_tlast", out_tlast, 1'b0);
    check("rst_out_data", out_dat, 32'h0);
    srcq[2].delete();
    apply_inputs();
    reset = 1'b1;

    // Single beat on stream 0.
    srcq[0].push_back(mk(16'h8001, 8'd3, 8'h5A));
    apply_inputs();
    out_rdy = 1'b1;
    cycle();
    check("t1_valid", out_vld, 1'b1);
    check("t1_data", out_dat, 32'h03FF8001);
    check("t1_dest", out_dest, 8'd3);
    check("t1_user", out_user, 8'h5A);
    check("t1_tlast", out_tlast, 1'b0);
    cycle();
    check("t1_valid_one_cycle", out_vld, 1'b0);

    // All four streams valid: round-robin from pointer 1 (stream 0 was last granted), no gaps.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++)
        srcq[i].push_back(mk(16'(i * 16'h4000 + k), 8'(i), 8'(k)));
    apply_inputs();
    for (int c = 0; c < 32; c++) begin
      cycle();
      check("t2_valid", out_vld, 1'b1);
      check("t2_order", out_dest, 8'((1 + c) % 4));
      if (c < 24) begin
        check("t3_fx_ready", fx_rdy, 4'b0001);
        check("t3_fx_valid", fx_vld, 1'b1);
        check("t3_fx_dest", fx_dest, 8'd0);
      end
    end
    cycle();
    check("t2_drain", out_vld, 1'b0);

    // Backpressure: hold the output for 5 cycles, then release and drain.
    srcq[0].push_back(mk(16'h7FFF, 8'd10, 8'd0));
    srcq[1].push_back(mk(16'h0001, 8'd11, 8'd1));
    srcq[2].push_back(mk(16'hFFFE, 8'd12, 8'd2));
    srcq[3].push_back(mk(16'h8000, 8'd13, 8'd3));
    apply_inputs();
    cycle();
    check("t4_first_dest", out_dest, 8'd11);
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t4_hold_valid", out_vld, 1'b1);
      check("t4_hold_data", out_dat, 32'h0B000001);
      check("t4_in_ready", in_rdy, 4'b0000);
    end
    out_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (all_empty() && sb.size() == 0 && !out_vld) break;
    end
    check("t4_drained", {31'(sb.size()), out_vld, 31'(n_out)}, {31'd0, 1'b0, 31'(n_in)});

    // Periodic tlast with two interleaved channels after a fresh reset.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      srcq[0].push_back(mk(16'(k), 8'd0, 8'(k)));
      srcq[1].push_back(mk(16'(16'hF000 | k), 8'd1, 8'(k)));
    end
    apply_inputs();
    for (int c = 0; c < 16; c++) begin
      cycle();
      check("t5_dest", out_dest, 8'(c % 2));
      check("t5_tlast", out_tlast, (c == 6 || c == 7 || c == 14 || c == 15));
    end
    cycle();

    // Reset while a beat sits in the output register.
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      srcq[i].push_back(mk(16'h1111, 8'(i), 8'd0));
      srcq[i].push_back(mk(16'h2222, 8'(i), 8'd1));
    end
    apply_inputs();
    repeat (4) cycle();
    check("t6_pre_valid", out_vld, 1'b1);
    check("t6_pre_dest", out_dest, 8'd2);
    reset = 1'b0;
    cycle();
    check("t6_rst_valid", out_vld, 1'b0);
    check("t6_rst_tlast", out_tlast, 1'b0);
    check("t6_rst_ready", in_rdy, 4'b0000);
`ifdef AXIS_COMBINER_STALL_CNT_EN
    check("t6_rst_stall", stall, 64'h0);
`endif
    reset = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    for (int k = 0; k < 6; k++) srcq[2].push_back(mk(16'(k), 8'd2, 8'(k)));
    out_rdy = 1'b1;
    apply_inputs();
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("t6_tlast", out_tlast, (c == 3));
    end
    cycle();
    check("t6_end_valid", out_vld, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
